// File: rtl/lsu_bus_master.sv
// lsu_bus_master: initiator side of the RV32 data-memory interface.
// Takes one load/store command (func3 encoding) and serialises it into byte-wide
// bus beats at base, base+1, ... (wrapping mod 2**ADDR_W). Load bytes are assembled
// little-endian and sign/zero-extended. Exactly one response pulse per command.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   req_valid_i / req_ready_o    command handshake
//   mem_read_i, mem_write_i      command type (exactly one must be set)
//   func3_i, address_i, wdata_i  size/sign, base byte address, store data
//   resp_valid_o, rdata_o, err_o one-cycle completion pulse, load result, illegal flag
//   bus_valid_o / bus_ready_i    beat handshake
//   bus_we_o, bus_addr_o, bus_wdata_o  beat direction, byte address, write byte
//   bus_rvalid_i, bus_rdata_i    returned read byte
module lsu_bus_master #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        func3_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [31:0]       wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              bus_valid_o,
  input  logic              bus_ready_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [7:0]        bus_rdata_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitR, StDone} state_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              illegal;
  logic [1:0]        last_idx;
  logic [31:0]       rbuf_merged;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] b);
    unique case (f3)
      3'b000:  extend = {{24{b[7]}}, b[7:0]};
      3'b001:  extend = {{16{b[15]}}, b[15:0]};
      3'b100:  extend = {24'h0, b[7:0]};
      3'b101:  extend = {16'h0, b[15:0]};
      default: extend = b;
    endcase
  endfunction

  // Decoded from the live inputs: only meaningful in the accepting IDLE cycle.
  assign illegal = (func3_i[1:0] == 2'b11) || (func3_i == 3'b110) ||
                   (mem_read_i == mem_write_i) || (mem_write_i && func3_i[2]);

  always_comb begin
    unique case (func3_q[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // Buffer with the byte arriving this cycle merged in, so the final byte can be
  // extended in the same cycle it is captured.
  always_comb begin
    rbuf_merged = rbuf_q;
    rbuf_merged[{idx_q, 3'b000} +: 8] = bus_rdata_i;
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    func3_d      = func3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    rbuf_d       = rbuf_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    bus_valid_o  = 1'b0;
    bus_we_o     = 1'b0;
    bus_addr_o   = '0;
    bus_wdata_o  = 8'h00;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          store_d = mem_write_i;
          func3_d = func3_i;
          addr_d  = address_i;
          wdata_d = wdata_i;
          idx_d   = 2'd0;
          rbuf_d  = 32'h0;
          if (illegal) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = StDone;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        bus_valid_o = 1'b1;
        bus_we_o    = store_q;
        bus_addr_o  = addr_q + ADDR_W'(idx_q);
        bus_wdata_o = store_q ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
        if (bus_ready_i) begin
          if (!store_q) begin
            state_d = StWaitR;
          end else if (idx_q == last_idx) begin
            rdata_d = 32'h0;
            err_d   = 1'b0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      StWaitR: begin
        if (bus_rvalid_i) begin
          rbuf_d = rbuf_merged;
          if (idx_q == last_idx) begin
            rdata_d = extend(func3_q, rbuf_merged);
            err_d   = 1'b0;
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        resp_valid_o = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      store_q <= 1'b0;
      func3_q <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      idx_q   <= 2'd0;
      rbuf_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
module tb_lsu_bus_master;

  logic        clk, rst;
  logic        req_valid, req_ready, mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] address, wdata;
  logic        resp_valid, err;
  logic [31:0] rdata;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;

  lsu_bus_master #(.ADDR_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .func3_i      (func3),
    .address_i    (address),
    .wdata_i      (wdata),
    .resp_valid_o (resp_valid),
    .rdata_o      (rdata),
    .err_o        (err),
    .bus_valid_o  (bus_valid),
    .bus_ready_i  (bus_ready),
    .bus_we_o     (bus_we),
    .bus_addr_o   (bus_addr),
    .bus_wdata_o  (bus_wdata),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Byte memory model and beat log.
  logic [7:0]  mem [256];
  logic [31:0] log_addr [$];
  logic [7:0]  log_data [$];
  logic        log_we   [$];
  int          valid_cnt    = 0;
  int          unstable_cnt = 0;
  int          stall_cnt    = 0;
  logic        stall_mode   = 1'b0;
  int          wait_cnt     = 0;
  logic        prev_stall   = 1'b0;
  logic [31:0] prev_addr    = 32'h0;
  logic [7:0]  prev_wdata   = 8'h00;
  logic        rsp_rd;
  logic [31:0] rsp_addr;

  // Bus responder: logs accepted beats, returns read bytes one cycle after
  // acceptance, and optionally holds bus_ready low 3 cycles per beat.
  initial begin
    bus_ready  = 1'b1;
    bus_rvalid = 1'b0;
    bus_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_valid) valid_cnt++;
      if (bus_valid && prev_stall && (bus_addr != prev_addr || bus_wdata != prev_wdata))
        unstable_cnt++;
      if (bus_valid && !bus_ready) stall_cnt++;
      prev_stall = bus_valid && !bus_ready;
      prev_addr  = bus_addr;
      prev_wdata = bus_wdata;
      if (bus_valid && bus_ready) begin
        log_addr.push_back(bus_addr);
        log_data.push_back(bus_wdata);
        log_we.push_back(bus_we);
      end
      rsp_rd   = bus_valid && bus_ready && !bus_we;
      rsp_addr = bus_addr;
      @(posedge clk);
      #1;
      bus_rvalid = rsp_rd;
      bus_rdata  = rsp_rd ? mem[rsp_addr[7:0]] : 8'h00;
      if (!stall_mode) begin
        bus_ready = 1'b1;
      end else if (bus_valid && wait_cnt == 3) begin
        bus_ready = 1'b1;
        wait_cnt  = 0;
      end else begin
        bus_ready = 1'b0;
        if (bus_valid) wait_cnt++;
      end
    end
  end

  // Issues one command and returns the cycle offset (accept at T) of resp_valid,
  // or -1 if no response arrives. Returns at the negedge of the response cycle.
  task automatic run_cmd(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] w, output int lat);
    log_addr.delete();
    log_data.delete();
    log_we.delete();
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    func3     = f3;
    address   = a;
    wdata     = w;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  int          lat;
  int          v0;
  int          pulses;
  logic [31:0] exp_addr [4];

  initial begin
    logic [31:0] sw_data;
    rst = 1'b1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    func3 = 3'b000; address = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h80;
    mem[8'h30] = 8'h01; mem[8'h31] = 8'h80;
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;

    // Reset state
    @(negedge clk);
    check_eq("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_eq("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    check_eq("rst_bus_we", {31'h0, bus_we}, 32'h0);
    check_eq("rst_err", {31'h0, err}, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_bus_addr", bus_addr, 32'h0);
    check_eq("rst_bus_wdata", {24'h0, bus_wdata}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Loads
    run_cmd(1'b1, 1'b0, 3'b000, 32'h20, 32'h0, lat);
    check_eq("lb_lat", lat, 3);
    check_eq("lb_rdata", rdata, 32'hFFFFFF80);
    check_eq("lb_err", {31'h0, err}, 32'h0);
    check_eq("lb_addr", (log_addr.size() > 0) ? log_addr[0] : 32'hDEAD0000, 32'h20);
    check_eq("lb_we", (log_we.size() > 0) ? {31'h0, log_we[0]} : 32'h2, 32'h0);
    @(negedge clk);
    check_eq("lb_hold_rdata", rdata, 32'hFFFFFF80);
    check_eq("lb_single_pulse", {31'h0, resp_valid}, 32'h0);

    run_cmd(1'b1, 1'b0, 3'b100, 32'h20, 32'h0, lat);
    check_eq("lbu_rdata", rdata, 32'h00000080);
    run_cmd(1'b1, 1'b0, 3'b001, 32'h30, 32'h0, lat);
    check_eq("lh_lat", lat, 5);
    check_eq("lh_rdata", rdata, 32'hFFFF8001);
    run_cmd(1'b1, 1'b0, 3'b101, 32'h30, 32'h0, lat);
    check_eq("lhu_rdata", rdata, 32'h00008001);
    run_cmd(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, lat);
    check_eq("lw_lat", lat, 9);
    check_eq("lw_rdata", rdata, 32'h44332211);

    // Store word
    sw_data = 32'hDEADBEEF;
    run_cmd(1'b0, 1'b1, 3'b010, 32'h10, sw_data, lat);
    check_eq("sw_lat", lat, 5);
    check_eq("sw_rdata", rdata, 32'h0);
    check_eq("sw_err", {31'h0, err}, 32'h0);
    check_eq("sw_nbeats", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check_eq($sformatf("sw_addr%0d", i), log_addr[i], 32'h10 + i);
      check_eq($sformatf("sw_data%0d", i), {24'h0, log_data[i]}, {24'h0, sw_data[8*i +: 8]});
      check_eq($sformatf("sw_we%0d", i), {31'h0, log_we[i]}, 32'h1);
    end

    // Load word across the top of the address space
    exp_addr[0] = 32'hFFFFFFFE; exp_addr[1] = 32'hFFFFFFFF;
    exp_addr[2] = 32'h00000000; exp_addr[3] = 32'h00000001;
    run_cmd(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, lat);
    check_eq("wrap_rdata", rdata, 32'hD4C3B2A1);
    check_eq("wrap_nbeats", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++)
      check_eq($sformatf("wrap_addr%0d", i), log_addr[i], exp_addr[i]);

    // Store half with bus_ready stalled 3 cycles per beat
    stall_mode   = 1'b1;
    wait_cnt     = 0;
    stall_cnt    = 0;
    unstable_cnt = 0;
    run_cmd(1'b0, 1'b1, 3'b001, 32'h50, 32'h1234A5B6, lat);
    stall_mode = 1'b0;
    check_eq("sh_lat", lat, 9);
    check_eq("sh_stall_cycles", stall_cnt, 6);
    check_eq("sh_stable", unstable_cnt, 0);
    check_eq("sh_nbeats", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check_eq("sh_addr0", log_addr[0], 32'h50);
      check_eq("sh_data0", {24'h0, log_data[0]}, 32'hB6);
      check_eq("sh_addr1", log_addr[1], 32'h51);
      check_eq("sh_data1", {24'h0, log_data[1]}, 32'hA5);
    end

    // Illegal commands
    v0 = valid_cnt;
    run_cmd(1'b0, 1'b1, 3'b011, 32'h60, 32'h0, lat);
    check_eq("ill_f3_lat", lat, 1);
    check_eq("ill_f3_err", {31'h0, err}, 32'h1);
    check_eq("ill_f3_rdata", rdata, 32'h0);
    run_cmd(1'b1, 1'b1, 3'b010, 32'h60, 32'h0, lat);
    check_eq("ill_rw_lat", lat, 1);
    check_eq("ill_rw_err", {31'h0, err}, 32'h1);
    run_cmd(1'b0, 1'b0, 3'b000, 32'h60, 32'h0, lat);
    check_eq("ill_none_err", {31'h0, err}, 32'h1);
    run_cmd(1'b0, 1'b1, 3'b100, 32'h60, 32'h0, lat);
    check_eq("ill_sbu_err", {31'h0, err}, 32'h1);
    run_cmd(1'b1, 1'b0, 3'b110, 32'h60, 32'h0, lat);
    check_eq("ill_110_err", {31'h0, err}, 32'h1);
    check_eq("ill_no_beats", valid_cnt - v0, 0);
    run_cmd(1'b1, 1'b0, 3'b100, 32'h20, 32'h0, lat);
    check_eq("post_ill_err", {31'h0, err}, 32'h0);
    check_eq("post_ill_rdata", rdata, 32'h00000080);

    // Reset during ISSUE: bus_valid drops in the same cycle
    @(posedge clk);
    #1;
    req_valid = 1'b1; mem_read = 1'b1; func3 = 3'b010; address = 32'h40;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check_eq("issue_bus_valid", {31'h0, bus_valid}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("issue_rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset during WAIT_R of lw: no response, then normal operation
    @(posedge clk);
    #1;
    req_valid = 1'b1; mem_read = 1'b1; func3 = 3'b010; address = 32'h40;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("waitr_rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    check_eq("waitr_rst_resp", {31'h0, resp_valid}, 32'h0);
    check_eq("waitr_rst_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid || bus_valid) pulses++;
    end
    check_eq("waitr_rst_quiet", pulses, 0);
    run_cmd(1'b1, 1'b0, 3'b001, 32'h30, 32'h0, lat);
    check_eq("after_rst_lat", lat, 5);
    check_eq("after_rst_rdata", rdata, 32'hFFFF8001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
